pipelined_addsub: RTL and testbench

//  Parametrised, pipelined two's-complement adder/subtractor. Successor to the

---
 rtl/pipelined_addsub.sv | 112 +++++++++++
 tb/tb_pipelined_addsub.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor, one SEG-bit carry segment
// per stage, valid/ready stream with full-pipeline stall on backpressure.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEGW = (SEG > 0) ? SEG : 1;
  localparam int NSEG = WIDTH / SEGW;
  localparam int MSB  = WIDTH - 1;

  if ((SEG < 1) || ((WIDTH % SEGW) != 0)) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a multiple of SEG >= 1");
  end

  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] s_q   [NSEG];
  logic [WIDTH-1:0] a_d   [NSEG];
  logic [WIDTH-1:0] b_d   [NSEG];
  logic [WIDTH-1:0] s_d   [NSEG];
  logic [WIDTH-1:0] a_src [NSEG];
  logic [WIDTH-1:0] b_src [NSEG];
  logic [WIDTH-1:0] s_src [NSEG];
  logic [SEGW:0]    seg_r [NSEG];
  logic [NSEG-1:0]  c_q, c_d, c_src;
  logic [NSEG-1:0]  v_q, v_d, v_src;
  logic             stall;

  assign out_valid = v_q[NSEG-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  // Stage 0 sees the raw operands; later stages see the previous register.
  always_comb begin
    a_src[0] = a;
    b_src[0] = sub ? ~b : b;
    s_src[0] = '0;
    c_src    = '0;
    v_src    = '0;
    c_src[0] = sub ^ cin;
    v_src[0] = in_valid && !stall;
    for (int k = 1; k < NSEG; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end
  end

  always_comb begin
    c_d = c_q;
    v_d = v_q;
    for (int k = 0; k < NSEG; k++) begin
      seg_r[k] = {1'b0, a_src[k][k*SEGW +: SEGW]}
               + {1'b0, b_src[k][k*SEGW +: SEGW]}
               + {{SEGW{1'b0}}, c_src[k]};
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      if (!stall) begin
        a_d[k] = a_src[k];
        b_d[k] = b_src[k];
        s_d[k] = s_src[k];
        s_d[k][k*SEGW +: SEGW] = seg_r[k][SEGW-1:0];
        c_d[k] = seg_r[k][SEGW];
        v_d[k] = v_src[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign sum  = s_q[NSEG-1];
  assign cout = c_q[NSEG-1];
  assign ovf  = (a_q[NSEG-1][MSB] == b_q[NSEG-1][MSB])
             && (s_q[NSEG-1][MSB] != a_q[NSEG-1][MSB]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed table, randomized stream against
// an integer-arithmetic reference, stall, reset and single-stage cases.
module tb_pipelined_addsub;

  logic        clk = 0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] a8, b8, sum8;
  logic       cin8, sub8, cout8, ovf8;

  pipelined_addsub #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_addsub #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: signed range for ovf, unsigned carry/borrow for cout.
  function automatic logic [33:0] gold(input logic [31:0] x,
                                       input logic [31:0] y,
                                       input logic ci, input logic s);
    longint sx, sy, ux, uy, cl, t, u;
    logic   c, o;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    cl = ci ? 1 : 0;
    if (!s) begin
      t = sx + sy + cl;
      u = ux + uy + cl;
      c = (u >= 64'sh1_0000_0000);
    end else begin
      t = sx - sy - cl;
      u = ux - uy - cl;
      c = (u >= 0);
    end
    o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    return {o, c, u[31:0]};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [33:0] exp_q[$];
  bit          mon_en = 0;
  bit          force_stall = 0;
  int          cyc = 0;
  int          rx_cnt = 0;
  int          first_rx = 0;
  int          last_rx = 0;

  always @(negedge clk) begin
    logic [33:0] e;
    cyc++;
    if (!rst && mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("mon_sum", 64'(sum), 64'(e[31:0]));
          check("mon_cout", 64'(cout), 64'(e[32]));
          check("mon_ovf", 64'(ovf), 64'(e[33]));
          rx_cnt++;
          if (rx_cnt == 1) first_rx = cyc;
          last_rx = cyc;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(gold(a, b, cin, sub));
    end
  end

  task automatic drive(input int n, input int bub, input int bp);
    int sent = 0;
    bit took = 0;
    while (sent < n) begin
      @(posedge clk); #1;
      out_ready = !force_stall && ($urandom_range(0, 99) >= bp);
      if (took) in_valid = 0;
      if (!in_valid && ($urandom_range(0, 99) >= bub)) begin
        a = rnd32();
        b = rnd32();
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        in_valid = 1;
      end
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) sent++;
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = !force_stall;
  endtask

  task automatic drain();
    int w = 0;
    out_ready = 1;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [31:0] va, vb;
    logic        vc, vs;
    logic [31:0] es;
    logic        ec, eo;
  } vec_t;

  vec_t vt[9];

  initial begin
    int lat;
    int cnt;
    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0};
    vt[1] = '{32'h8000_0000, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 1, 1};
    vt[2] = '{32'h0000_0000, 32'h0000_0001, 0, 1, 32'hFFFF_FFFF, 0, 0};
    vt[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1};
    vt[4] = '{32'h0000_00FF, 32'h0000_0001, 1, 0, 32'h0000_0101, 0, 0};
    vt[5] = '{32'h0000_0005, 32'h0000_0003, 1, 1, 32'h0000_0001, 1, 0};
    vt[6] = '{32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1};
    vt[7] = '{32'h0000_0100, 32'h0000_0001, 0, 1, 32'h0000_00FF, 1, 0};
    vt[8] = '{32'h00FF_FFFF, 32'h0000_0000, 1, 0, 32'h0100_0000, 0, 0};

    rst = 1;
    in_valid = 0; out_ready = 1;
    a = 0; b = 0; cin = 0; sub = 0;
    in_valid8 = 0; out_ready8 = 1;
    a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst8_out_valid", 64'(out_valid8), 64'd0);
    check("rst8_sum", 64'(sum8), 64'd0);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);

    // Directed vectors, one beat at a time, latency measured per beat.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      a = vt[i].va; b = vt[i].vb;
      cin = vt[i].vc; sub = vt[i].vs;
      in_valid = 1;
      @(negedge clk);
      @(posedge clk); #1;
      in_valid = 0;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vt[i].es));
      check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vt[i].ec));
      check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vt[i].eo));
    end
    @(negedge clk);

    // Back-to-back random stream, no backpressure.
    mon_en = 1;
    rx_cnt = 0;
    drive(1000, 0, 0);
    drain();
    check("b2b_count", 64'(rx_cnt), 64'd1000);
    check("b2b_one_per_cycle", 64'(last_rx - first_rx), 64'd999);

    // Random bubbles and random backpressure.
    rx_cnt = 0;
    drive(300, 30, 30);
    drain();
    check("bp_count", 64'(rx_cnt), 64'd300);

    // Full pipe held for 5 cycles.
    rx_cnt = 0;
    fork
      drive(12, 0, 0);
      begin : stall_ctl
        int w = 0;
        logic [33:0] e;
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        check("stall_fill_timeout", 64'(w < 20), 64'd1);
        @(posedge clk); #2;
        force_stall = 1;
        out_ready = 0;
        repeat (5) begin
          @(negedge clk);
          e = exp_q[0];
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          check("stall_sum", 64'(sum), 64'(e[31:0]));
          check("stall_cout", 64'(cout), 64'(e[32]));
          check("stall_ovf", 64'(ovf), 64'(e[33]));
        end
        @(posedge clk); #2;
        force_stall = 0;
        out_ready = 1;
      end
    join
    drain();
    check("stall_count", 64'(rx_cnt), 64'd12);

    // Reset with beats in flight: nothing may emerge afterwards.
    drive(3, 0, 0);
    out_ready = 0;
    @(posedge clk); #3;
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst = 1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_sum", 64'(sum), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    out_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("post_rst_stale", 64'(cnt), 64'd0);
    mon_en = 0;

    // Single-stage instance.
    @(posedge clk); #1;
    a8 = 8'h7F; b8 = 8'h01; cin8 = 0; sub8 = 0;
    in_valid8 = 1;
    @(negedge clk);
    check("w8_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
    a8 = 8'h00; b8 = 8'h01; sub8 = 1;
    out_ready8 = 0;
    @(negedge clk);
    check("w8_out_valid", 64'(out_valid8), 64'd1);
    check("w8_sum", 64'(sum8), 64'h80);
    check("w8_ovf", 64'(ovf8), 64'd1);
    check("w8_cout", 64'(cout8), 64'd0);
    check("w8_stall_ready", 64'(in_ready8), 64'd0);
    @(posedge clk); #1;
    out_ready8 = 1;
    @(negedge clk);
    check("w8_held_sum", 64'(sum8), 64'h80);
    @(posedge clk); #1;
    in_valid8 = 0;
    @(negedge clk);
    check("w8_sub_valid", 64'(out_valid8), 64'd1);
    check("w8_sub_sum", 64'(sum8), 64'hFF);
    check("w8_sub_cout", 64'(cout8), 64'd0);
    check("w8_sub_ovf", 64'(ovf8), 64'd0);
    @(negedge clk);
    check("w8_empty", 64'(out_valid8), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
